// File: rtl/i2c_pkg.sv
// Shared constants for the MPU-style I2C target model.
// States, register map and the snapshot byte selector.
package i2c_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;

  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] REG_ACCEL_ZOUT_L = 8'h40;
  localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] REG_WHO_AM_I     = 8'h75;

  function automatic logic [7:0] accel_byte(
    input logic [47:0] d,
    input logic [7:0]  a
  );
    logic [7:0] r;
    r = 8'h00;
    case (a)
      REG_ACCEL_XOUT_H:        r = d[47:40];
      REG_ACCEL_XOUT_H + 8'd1: r = d[39:32];
      REG_ACCEL_XOUT_H + 8'd2: r = d[31:24];
      REG_ACCEL_XOUT_H + 8'd3: r = d[23:16];
      REG_ACCEL_XOUT_H + 8'd4: r = d[15:8];
      REG_ACCEL_ZOUT_L:        r = d[7:0];
      default:                 r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Pad synchronizer with edge detect for one I2C line.
// I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, prev;

  // Idle-high reset so release never looks like an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= pad;
      s2 <= s1;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic h1, h2, filt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h1   <= 1'b1;
      h2   <= 1'b1;
      filt <= 1'b1;
    end else begin
      h1   <= s2;
      h2   <= h1;
      filt <= (s2 & h1) | (s2 & h2) | (h1 & h2);
    end
  end

  assign level = filt;
`else
  assign level = s2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b1;
    else       prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/i2c_target_mpu.sv
// I2C target standing in for an MPU-class motion sensor.
// Optional input filter: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_mpu
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR     = 7'h69,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
  parameter logic [7:0] PWR_RST_VAL  = 8'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [47:0] accel_data,
  output logic [7:0]  pwr_mgmt,
  output logic        sleep,
  output logic        wr_strobe,
  output logic        busy
);

  logic       scl, scl_rise, scl_fall;
  logic       sda, sda_rise, sda_fall;
  logic       start, stop, rw;
  logic [3:0] state, bit_cnt;
  logic [7:0] shreg, tx, ptr, rd_byte, wr_data;
  logic [47:0] snap;

  i2c_line_sync u_scl (
    .clk   (clk),
    .reset (reset),
    .pad   (scl_i),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync u_sda (
    .clk   (clk),
    .reset (reset),
    .pad   (sda_i),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start   = scl & sda_fall;
  assign stop    = scl & sda_rise;
  assign wr_data = {shreg[6:0], sda};
  assign sleep   = pwr_mgmt[6];

  always_comb begin
    rd_byte = accel_byte(snap, ptr);
    if (ptr == REG_PWR_MGMT_1) rd_byte = pwr_mgmt;
    if (ptr == REG_WHO_AM_I)   rd_byte = WHO_AM_I_VAL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      tx        <= 8'h00;
      ptr       <= 8'h00;
      snap      <= 48'h0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      pwr_mgmt  <= PWR_RST_VAL;
      wr_strobe <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (stop) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start) begin
        state   <= ST_ADDR;
        bit_cnt <= 4'd0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shreg   <= wr_data;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (shreg[7:1] == I2C_ADDR) begin
                state  <= ST_ADDR_ACK;
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= shreg[0];
                if (shreg[0]) snap <= accel_data;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                state  <= ST_RDATA;
                tx     <= rd_byte;
                sda_oe <= ~rd_byte[7];
              end else begin
                state  <= ST_PTR;
                sda_oe <= 1'b0;
              end
            end
          end
          ST_PTR: begin
            if (scl_rise) begin
              shreg   <= wr_data;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              ptr     <= shreg;
              sda_oe  <= 1'b1;
              state   <= ST_PTR_ACK;
            end
          end
          ST_WDATA: begin
            if (scl_rise) begin
              shreg   <= wr_data;
              bit_cnt <= bit_cnt + 4'd1;
              // Commit on the 8th rising edge; ACK follows on the fall
              if (bit_cnt == 4'd7) begin
                wr_strobe <= 1'b1;
                ptr       <= ptr + 8'd1;
                if (ptr == REG_PWR_MGMT_1) pwr_mgmt <= wr_data;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              sda_oe  <= 1'b1;
              state   <= ST_WDATA_ACK;
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                state   <= ST_RDATA_ACK;
              end else begin
                tx     <= {tx[6:0], 1'b0};
                sda_oe <= ~tx[6];
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              shreg <= wr_data;
              ptr   <= ptr + 8'd1;
            end else if (scl_fall) begin
              if (shreg[0]) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state  <= ST_RDATA;
                tx     <= rd_byte;
                sda_oe <= ~rd_byte[7];
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_mpu.sv
// Directed bench for i2c_target_mpu with a bit-level controller model.
// Open-drain SDA is resolved here from the controller and sda_oe.
module tb_i2c_target_mpu;

  localparam int Q = 6;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_bus;
  logic        sda_oe;
  logic [47:0] accel_data = 48'h0;
  logic [7:0]  pwr_mgmt;
  logic        sleep;
  logic        wr_strobe;
  logic        busy;

  int total = 0;
  int bad = 0;
  int ws_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  assign sda_bus = m_sda & ~sda_oe;

  i2c_target_mpu dut (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (m_scl),
    .sda_i      (sda_bus),
    .sda_oe     (sda_oe),
    .accel_data (accel_data),
    .pwr_mgmt   (pwr_mgmt),
    .sleep      (sleep),
    .wr_strobe  (wr_strobe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) ws_cnt++;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; cyc(Q);
    m_scl = 1'b1; cyc(Q);
    m_sda = 1'b0; cyc(Q);
    m_scl = 1'b0; cyc(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; cyc(Q);
    m_scl = 1'b1; cyc(Q);
    m_sda = 1'b1; cyc(Q);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b; cyc(Q);
    m_scl = 1'b1; cyc(Q);
    s = sda_bus; cyc(Q);
    m_scl = 1'b0; cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], d);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      b = {b[6:0], s};
    end
    clock_bit(nack, s);
  endtask

  task automatic chk_ack(input string nm, input logic a);
    total++;
    if (a !== 1'b0) begin
      bad++;
      $display("FAIL %s: ack got %b want 0", nm, a);
    end
  endtask

  task automatic test_reset();
    cyc(3);
    total++;
    if (sda_oe !== 1'b0) begin
      bad++; $display("FAIL rst_oe: got %b want 0", sda_oe);
    end
    total++;
    if (pwr_mgmt !== 8'h40) begin
      bad++; $display("FAIL rst_pwr: got %h want 40", pwr_mgmt);
    end
    total++;
    if (sleep !== 1'b1) begin
      bad++; $display("FAIL rst_sleep: got %b want 1", sleep);
    end
    total++;
    if (wr_strobe !== 1'b0) begin
      bad++; $display("FAIL rst_ws: got %b want 0", wr_strobe);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    reset = 1'b0;
    cyc(4);
  endtask

  task automatic test_write_pwr();
    logic a;
    int w0, b0;
    w0 = ws_cnt;
    b0 = busy_cnt;
    i2c_start();
    write_byte(8'hD2, a); chk_ack("wr_addr", a);
    write_byte(8'h6B, a); chk_ack("wr_ptr", a);
    write_byte(8'h00, a); chk_ack("wr_data", a);
    i2c_stop();
    cyc(4);
    total++;
    if (pwr_mgmt !== 8'h00) begin
      bad++; $display("FAIL wr_pwr: got %h want 00", pwr_mgmt);
    end
    total++;
    if (sleep !== 1'b0) begin
      bad++; $display("FAIL wr_sleep: got %b want 0", sleep);
    end
    total++;
    if (ws_cnt - w0 !== 1) begin
      bad++; $display("FAIL wr_strobes: got %0d want 1", ws_cnt - w0);
    end
    total++;
    if (busy_cnt == b0) begin
      bad++; $display("FAIL wr_busy_seen: got 0 cycles want >0");
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL wr_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_burst_read();
    logic a;
    logic [7:0] d;
    logic [7:0] exp_b [6];
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    accel_data = 48'h0102_0304_0506;
    i2c_start();
    write_byte(8'hD2, a); chk_ack("br_addr_w", a);
    write_byte(8'h3B, a); chk_ack("br_ptr", a);
    i2c_start();
    write_byte(8'hD3, a); chk_ack("br_addr_r", a);
    for (int i = 0; i < 6; i++) begin
      read_byte(i == 5, d);
      if (i == 1) accel_data = 48'hFFFF_FFFF_FFFF;
      total++;
      if (d !== exp_b[i]) begin
        bad++;
        $display("FAIL br_byte%0d: got %h want %h", i, d, exp_b[i]);
      end
    end
    i2c_stop();
    cyc(4);
  endtask

  task automatic test_who_am_i();
    logic a;
    logic [7:0] d;
    for (int k = 0; k < 2; k++) begin
      i2c_start();
      write_byte(8'hD2, a); chk_ack("who_addr_w", a);
      write_byte(8'h75, a); chk_ack("who_ptr", a);
      i2c_start();
      write_byte(8'hD3, a); chk_ack("who_addr_r", a);
      read_byte(1'b1, d);
      i2c_stop();
      total++;
      if (d !== 8'h68) begin
        bad++; $display("FAIL who_read%0d: got %h want 68", k, d);
      end
      if (k == 0) begin
        i2c_start();
        write_byte(8'hD2, a); chk_ack("who_wr_addr", a);
        write_byte(8'h75, a); chk_ack("who_wr_ptr", a);
        write_byte(8'h12, a); chk_ack("who_wr_data", a);
        i2c_stop();
      end
    end
    total++;
    if (pwr_mgmt !== 8'h00) begin
      bad++; $display("FAIL who_pwr_kept: got %h want 00", pwr_mgmt);
    end
    cyc(4);
  endtask

  task automatic test_bad_addr();
    logic a;
    int o0, b0;
    o0 = oe_cnt;
    b0 = busy_cnt;
    i2c_start();
    write_byte(8'hA0, a);
    total++;
    if (a !== 1'b1) begin
      bad++; $display("FAIL bad_nack: got %b want 1", a);
    end
    write_byte(8'h55, a);
    i2c_stop();
    cyc(4);
    total++;
    if (oe_cnt != o0) begin
      bad++; $display("FAIL bad_oe: got %0d cycles want 0", oe_cnt - o0);
    end
    total++;
    if (busy_cnt != b0) begin
      bad++; $display("FAIL bad_busy: got %0d cycles want 0", busy_cnt - b0);
    end
  endtask

  task automatic test_ptr_wrap();
    logic a;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hD2, a); chk_ack("wrap_addr_w", a);
    write_byte(8'hFF, a); chk_ack("wrap_ptr", a);
    i2c_start();
    write_byte(8'hD3, a); chk_ack("wrap_addr_r", a);
    read_byte(1'b0, d);
    total++;
    if (d !== 8'h00) begin
      bad++; $display("FAIL wrap_b0: got %h want 00", d);
    end
    read_byte(1'b1, d);
    total++;
    if (d !== 8'h00) begin
      bad++; $display("FAIL wrap_b1: got %h want 00", d);
    end
    i2c_stop();
    cyc(4);
    total++;
    if (dut.ptr !== 8'h01) begin
      bad++; $display("FAIL wrap_ptr_end: got %h want 01", dut.ptr);
    end
  endtask

  task automatic test_oe_latency();
    logic [7:0] adr;
    logic d;
    adr = 8'hD2;
    i2c_start();
    for (int i = 7; i >= 1; i--) clock_bit(adr[i], d);
    m_sda = adr[0]; cyc(Q);
    m_scl = 1'b1; cyc(2 * Q);
    m_scl = 1'b0; cyc(LAT - 1);
    total++;
    if (sda_oe !== 1'b0) begin
      bad++; $display("FAIL lat_early: got %b want 0", sda_oe);
    end
    cyc(1);
    total++;
    if (sda_oe !== 1'b1) begin
      bad++; $display("FAIL lat_ack: got %b want 1", sda_oe);
    end
    m_sda = 1'b1; cyc(Q - LAT);
    m_scl = 1'b1; cyc(2 * Q);
    m_scl = 1'b0; cyc(Q);
    i2c_stop();
    cyc(4);
  endtask

  task automatic test_reset_mid();
    logic a;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hD3, a); chk_ack("mid_addr", a);
    total++;
    if (sda_oe !== 1'b1) begin
      bad++; $display("FAIL mid_pre_oe: got %b want 1", sda_oe);
    end
    reset = 1'b1;
    #1;
    total++;
    if (sda_oe !== 1'b0) begin
      bad++; $display("FAIL mid_async_oe: got %b want 0", sda_oe);
    end
    total++;
    if (pwr_mgmt !== 8'h40) begin
      bad++; $display("FAIL mid_pwr: got %h want 40", pwr_mgmt);
    end
    m_sda = 1'b1;
    m_scl = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(Q);
    i2c_start();
    write_byte(8'hD3, a); chk_ack("mid_readdr", a);
    read_byte(1'b1, d);
    i2c_stop();
    total++;
    if (d !== 8'h00) begin
      bad++; $display("FAIL mid_read: got %h want 00", d);
    end
    cyc(4);
  endtask

  initial begin
    test_reset();
    test_write_pwr();
    test_burst_read();
    test_who_am_i();
    test_bad_addr();
    test_ptr_wrap();
    test_oe_latency();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
